// File: rtl/seq_alu_pkg.sv
// Shared ALU definitions: operation encodings and the default datapath width.
package seq_alu_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_MUL = 4'b0011,
    ALU_SUB = 4'b0110
  } aluOperations_t;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one bit of B per cycle, LSB first,
// keeping the low XLEN bits of the product.
module shift_add_mul #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_product
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  logic            r_busy;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] w_acc_next;
  logic            w_last;
  logic            w_load;

  assign w_load     = i_start && !r_busy;
  assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);
  assign w_last     = r_busy && (r_cnt == CW'(XLEN - 1));

  // o_done marks the cycle whose rising edge retires the final iteration,
  // so the caller can register o_product on that same edge.
  assign o_busy    = r_busy;
  assign o_done    = w_last;
  assign o_product = w_acc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
    end else if (r_busy) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      if (w_last) r_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_load) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_acc <= '0;
    end else if (r_busy) begin
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_acc <= w_acc_next;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ADD/SUB/AND/OR with a done pulse; defining
// SEQ_ALU_MUL_EN adds an XLEN-cycle shift-add MUL (opcode 0011).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  aluOperations_t  aluControl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy,
  output logic            done
);

`ifdef SEQ_ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`else
  typedef enum logic {IDLE, DONE} state_t;
`endif

  state_t          r_state;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_done;
  logic [XLEN-1:0] w_alu;
  logic            w_is_mul;

  function automatic logic [XLEN-1:0] alu_eval(input aluOperations_t op,
                                               input logic [XLEN-1:0] x,
                                               input logic [XLEN-1:0] y);
    case (op)
      ALU_AND: alu_eval = x & y;
      ALU_OR:  alu_eval = x | y;
      ALU_SUB: alu_eval = x - y;
      default: alu_eval = x + y;
    endcase
  endfunction

  assign w_alu = alu_eval(aluControl, a, b);

`ifdef SEQ_ALU_MUL_EN
  logic            w_mul_start;
  logic            w_mul_busy;
  logic            w_mul_done;
  logic [XLEN-1:0] w_mul_prod;

  assign w_is_mul    = (aluControl == ALU_MUL);
  assign w_mul_start = start && (r_state != MUL) && w_is_mul;
  assign busy        = w_mul_busy;

  shift_add_mul #(.XLEN(XLEN)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_mul_start),
    .i_a       (a),
    .i_b       (b),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );
`else
  assign w_is_mul = 1'b0;
  assign busy     = 1'b0;
`endif

  // IDLE and DONE both accept a request, which is what makes back-to-back
  // single-cycle operations complete every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      if (r_state == MUL) begin
        if (w_mul_done) begin
          r_result <= w_mul_prod;
          r_zero   <= (w_mul_prod == '0);
          r_done   <= 1'b1;
          r_state  <= DONE;
        end
      end else
`endif
      begin
        r_state <= IDLE;
        if (start && w_is_mul) begin
`ifdef SEQ_ALU_MUL_EN
          r_state <= MUL;
`endif
        end else if (start) begin
          r_result <= w_alu;
          r_zero   <= (w_alu == '0);
          r_done   <= 1'b1;
          r_state  <= DONE;
        end
      end
    end
  end

  assign result = r_result;
  assign zero   = r_zero;
  assign done   = r_done;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu; MUL scenarios run when SEQ_ALU_MUL_EN is defined.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  aluOperations_t  aluControl;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;
  logic            done;

  int n_checks = 0;
  int n_pass   = 0;

  seq_alu #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .aluControl (aluControl),
    .a          (a),
    .b          (b),
    .result     (result),
    .zero       (zero),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [XLEN-1:0] model(input logic [3:0] op,
                                            input logic [XLEN-1:0] x,
                                            input logic [XLEN-1:0] y);
    case (op)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0110: return x - y;
`ifdef SEQ_ALU_MUL_EN
      4'b0011: return x * y;
`endif
      default: return x + y;
    endcase
  endfunction

  function automatic logic [3:0] pick_op();
    logic [3:0] op;
    case ($urandom_range(0, 5))
      0: op = 4'b0010;
      1: op = 4'b0110;
      2: op = 4'b0000;
      3: op = 4'b0001;
      default: op = 4'($urandom_range(0, 15));
    endcase
`ifdef SEQ_ALU_MUL_EN
    if (op == 4'b0011) op = 4'b1111;
`endif
    return op;
  endfunction

  // Drive one request for a single cycle; returns at the negedge of the done cycle.
  task automatic issue(input logic [3:0] op, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    @(negedge clk);
    start = 1'b1; aluControl = aluOperations_t'(op); a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (result !== '0 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_state: result=%h zero=%b busy=%b done=%b required 0/1/0/0", result, zero, busy, done);
    else n_pass++;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || result !== '0)
      $display("FAIL reset_wins_start: done=%b result=%h required 0/0", done, result);
    else n_pass++;
  endtask

  task automatic test_add;
    issue(4'b0010, 64'd5, 64'd7);
    n_checks++;
    if (done !== 1'b1 || result !== 64'd12 || zero !== 1'b0 || busy !== 1'b0)
      $display("FAIL add_5_7: done=%b result=%0d zero=%b busy=%b required 1/12/0/0", done, result, zero, busy);
    else n_pass++;
    a = 64'd100; b = 64'd200;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || result !== 64'd12)
      $display("FAIL add_hold: done=%b result=%0d required 0/12", done, result);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    start = 1'b1; aluControl = ALU_SUB; a = 64'd9; b = 64'd9;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || result !== '0 || zero !== 1'b1)
      $display("FAIL sub_9_9: done=%b result=%h zero=%b required 1/0/1", done, result, zero);
    else n_pass++;
    a = 64'd0; b = 64'd1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || result !== {XLEN{1'b1}} || zero !== 1'b0)
      $display("FAIL sub_0_1: done=%b result=%h zero=%b required 1/ffffffffffffffff/0", done, result, zero);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0)
      $display("FAIL b2b_done_drop: done=%b required 0", done);
    else n_pass++;
  endtask

  task automatic test_logic;
    logic [3:0]      ops [4];
    logic [XLEN-1:0] xs  [4];
    logic [XLEN-1:0] ys  [4];
    logic [XLEN-1:0] exp [4];
    ops = '{4'b0000, 4'b0001, 4'b1111, 4'b1000};
    xs  = '{64'hF0F0, 64'hF000, 64'd3, 64'd10};
    ys  = '{64'h0FF0, 64'h000F, 64'd4, 64'd20};
    exp = '{64'h00F0, 64'hF00F, 64'd7, 64'd30};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], xs[i], ys[i]);
      n_checks++;
      if (done !== 1'b1 || result !== exp[i])
        $display("FAIL logic_op_%0d: done=%b result=%h required 1/%h", i, done, result, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [3:0]      op;
    logic [XLEN-1:0] ra, rb, exp;
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      op = pick_op();
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 4) == 0) ? ra : {$urandom, $urandom};
      exp = model(op, ra, rb);
      start = 1'b1; aluControl = aluOperations_t'(op); a = ra; b = rb;
      @(negedge clk);
      start = 1'b0;
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || result !== exp || zero !== (exp == '0))
        $display("FAIL rand_%0d op=%b: done=%b busy=%b result=%h zero=%b required 1/0/%h/%b",
                 i, op, done, busy, result, zero, exp, (exp == '0));
      else n_pass++;
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || result !== exp)
          $display("FAIL rand_hold_%0d: done=%b result=%h required 0/%h", i, done, result, exp);
        else n_pass++;
      end
    end
  endtask

`ifdef SEQ_ALU_MUL_EN
  task automatic test_mul(input logic [XLEN-1:0] ma, input logic [XLEN-1:0] mb, input bit interfere);
    int cycles = 0, excl_bad = 0, stable_bad = 0;
    logic [XLEN-1:0] exp, before;
    exp = ma * mb;
    @(negedge clk);
    before = result;
    start = 1'b1; aluControl = ALU_MUL; a = ma; b = mb;
    @(negedge clk);
    start = 1'b0;
    while (busy === 1'b1 && cycles < XLEN + 8) begin
      if (done !== 1'b0) excl_bad++;
      if (result !== before) stable_bad++;
      cycles++;
      if (interfere && cycles == 10) begin
        start = 1'b1; aluControl = ALU_ADD; a = 64'd1; b = 64'd1;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (cycles != XLEN || excl_bad != 0 || stable_bad != 0)
      $display("FAIL mul_busy: busy_cycles=%0d excl_err=%0d unstable=%0d required %0d/0/0",
               cycles, excl_bad, stable_bad, XLEN);
    else n_pass++;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== exp || zero !== (exp == '0))
      $display("FAIL mul_result: done=%b busy=%b result=%h zero=%b required 1/0/%h/%b",
               done, busy, result, zero, exp, (exp == '0));
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== exp)
      $display("FAIL mul_after: done=%b busy=%b result=%h required 0/0/%h", done, busy, result, exp);
    else n_pass++;
  endtask

  task automatic test_reset_mid_mul(input int iter);
    int done_seen = 0;
    issue(4'b0011, {$urandom, $urandom} | 64'd1, {$urandom, $urandom} | 64'd1);
    repeat (iter - 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (result !== '0 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL mul_abort_%0d: result=%h zero=%b busy=%b done=%b required 0/1/0/0",
               iter, result, zero, busy, done);
    else n_pass++;
    repeat (XLEN + 2) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) done_seen++;
    end
    n_checks++;
    if (done_seen != 0)
      $display("FAIL mul_abort_quiet_%0d: stray cycles=%0d required 0", iter, done_seen);
    else n_pass++;
    issue(4'b0010, 64'd2, 64'd2);
    n_checks++;
    if (done !== 1'b1 || result !== 64'd4 || zero !== 1'b0)
      $display("FAIL add_after_abort_%0d: done=%b result=%0d required 1/4", iter, done, result);
    else n_pass++;
  endtask
`else
  task automatic test_mul_code_as_add;
    issue(4'b0011, 64'd3, 64'd4);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== 64'd7)
      $display("FAIL code_0011_as_add: done=%b busy=%b result=%0d required 1/0/7", done, busy, result);
    else n_pass++;
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b1; aluControl = ALU_ADD; a = 64'd5; b = 64'd5;
    test_reset();
    test_add();
    test_back_to_back();
    test_logic();
    test_random();
`ifdef SEQ_ALU_MUL_EN
    test_mul(64'd6, 64'd7, 1'b1);
    for (int i = 0; i < 3; i++) test_mul({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    test_mul({XLEN{1'b1}}, 64'd0, 1'b0);
    test_reset_mid_mul(30);
    test_reset_mid_mul(XLEN);
`else
    test_mul_code_as_add();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
- REQ-001 SHALL have parameter: XLEN, 64, operand/result width in bits.
- REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
- REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
- REQ-004 SHALL have port: start  input  1  request; accepted on an edge where start=1 and busy=0.
- REQ-005 SHALL have port: aluControl  input  aluOperations_t (4)  operation code from the ALU decoder.
- REQ-006 SHALL have port: a  input  XLEN  operand A, sampled on the accepting edge only.
- REQ-007 SHALL have port: b  input  XLEN  operand B, sampled on the accepting edge only.
- REQ-008 SHALL have port: result  output  XLEN  registered result; held until the next completion.
- REQ-009 SHALL have port: zero  output  1  registered; 1 when result == 0; updated together with result.
- REQ-010 SHALL have port: busy  output  1  1 while a multi-cycle operation is in progress.
- REQ-011 SHALL have port: done  output  1  single-cycle pulse marking the cycle result/zero become valid.

Function
- REQ-012 SHALL implement states IDLE, MUL (multi-cycle), DONE; DONE lasts exactly one cycle, then IDLE.
- REQ-013 SHALL, for ADD (0010), SUB (0110), AND (0000), OR (0001), register the result on the accepting edge and pass IDLE->DONE, so done=1 in the cycle directly after acceptance (latency 1).
- REQ-014 SHALL compute ADD/SUB modulo 2^XLEN with carries and overflow discarded; SUB = a - b in two's complement.
- REQ-015 SHALL treat any code not listed in REQ-013 as ADD, except MUL when compiled in (REQ-024).
- REQ-016 SHALL accept a new start in the DONE cycle, so back-to-back single-cycle operations give done=1 every cycle.
- REQ-017 SHALL ignore start while busy=1; the operands and operation in flight stay unchanged.
- REQ-018 SHALL keep result and zero stable from one done pulse to the next; no intermediate values appear on result.
- REQ-019 SHALL deassert busy in the DONE cycle and keep busy=0 in IDLE.
- REQ-020 SHALL make done and busy mutually exclusive in every cycle.

Reset
- REQ-021 SHALL, when reset=1 on a rising edge, set: state=IDLE, result=0, zero=1, busy=0, done=0, iteration counter=0.
- REQ-022 SHALL let reset win over a simultaneous start; that start is discarded.
- REQ-023 SHALL, when reset is asserted mid-MUL, abort the operation with no done pulse, even if it would complete on that edge.

Configuration
- REQ-024 SHALL, with macro SEQ_ALU_MUL_EN defined, decode MUL (0011) as an unsigned shift-add multiply giving the low XLEN bits of a*b.
  - busy=1 for exactly XLEN cycles after the accepting edge.
  - done=1 in the cycle after the XLEN-th iteration edge.
  - One bit of b is consumed per cycle, LSB first.
- REQ-025 SHALL, with SEQ_ALU_MUL_EN undefined:
  - Not build the MUL state or the counter.
  - Treat 0011 as ADD (latency 1).
  - Tie busy to 0.

Structure
- REQ-026 SHALL add the MUL encoding (4'b0011) to aluOperations_t in the shared defines package, next to ADD/SUB/AND/OR; the XLEN default constant also belongs in that package.
- REQ-027 SHALL keep the state enum local to seq_alu.
- REQ-028 SHALL place the iterative multiplier in one sub-module, shift_add_mul, with start/busy/done handshake; it is instantiated only under SEQ_ALU_MUL_EN.

Verification
- REQ-029 SHALL check: reset held 2 cycles -> result=0, zero=1, busy=0, done=0.
- REQ-030 SHALL check: start with ADD, a=5, b=7 -> next cycle done=1, result=12, zero=0; following cycle done=0, result still 12.
- REQ-031 SHALL check: SUB, a=9, b=9 then SUB, a=0, b=1 back-to-back -> done on two consecutive cycles.
  - First result=0, zero=1.
  - Second result=0xFFFF_FFFF_FFFF_FFFF, zero=0.
- REQ-032 SHALL check: AND 0xF0F0 & 0x0FF0 -> 0x00F0; OR 0xF000 | 0x000F -> 0xF00F; unused code 1111 with a=3, b=4 -> 7.
- REQ-033 SHALL check, with SEQ_ALU_MUL_EN defined: MUL a=6, b=7 -> busy=1 for 64 cycles, then done=1 with result=42. A start (ADD 1+1) issued mid-operation is ignored.
- REQ-034 SHALL check, with SEQ_ALU_MUL_EN defined: reset at iteration 30 of MUL -> no done pulse, outputs as in REQ-021. A fresh ADD 2+2 then completes with result=4.
